// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the multi-port scratch memory.
//   mem_op_t    - per-port operation code (value 3 is reserved and behaves as NONE)
//   mem_state_t - controller state: CLEAR (zero sweep after reset) or RUN
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_READ  = 2'd1,
    MEM_OP_WRITE = 2'd2
  } mem_op_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_mport_if.sv
// mem_mport_if: bundle of per-port request/response signals for mem_mport.
// Optional feature macro: MEM_BYTE_EN adds the per-port byte-enable vector 'be'.
//   op          [PORTS][2]        operation per port (see mem_pkg::mem_op_t)
//   addr        [PORTS][ADDR_W]   word address per port
//   wdata       [PORTS][DATA_W]   write data per port
//   be          [PORTS][DATA_W/8] byte enables per port (MEM_BYTE_EN only)
//   rdata       [PORTS][DATA_W]   registered read data
//   valid       [PORTS]           one-cycle pulse, rdata of that port holds a read result
//   busy        1                 reset/clear sweep in progress, requests ignored
//   wr_conflict 1                 pulse, same-address write collision on the previous edge
// modport master drives requests (load/store units), modport slave is the memory.
interface mem_mport_if #(
  parameter int unsigned PORTS  = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 13
);

  logic [PORTS-1:0][1:0]        op;
  logic [PORTS-1:0][ADDR_W-1:0] addr;
  logic [PORTS-1:0][DATA_W-1:0] wdata;
  logic [PORTS-1:0][DATA_W-1:0] rdata;
  logic [PORTS-1:0]             valid;
  logic                         busy;
  logic                         wr_conflict;

`ifdef MEM_BYTE_EN
  logic [PORTS-1:0][DATA_W/8-1:0] be;

  modport master (
    output op, addr, wdata, be,
    input  rdata, valid, busy, wr_conflict
  );

  modport slave (
    input  op, addr, wdata, be,
    output rdata, valid, busy, wr_conflict
  );
`else
  modport master (
    output op, addr, wdata,
    input  rdata, valid, busy, wr_conflict
  );

  modport slave (
    input  op, addr, wdata,
    output rdata, valid, busy, wr_conflict
  );
`endif

endinterface

// File: rtl/mem_wr_arb.sv
// mem_wr_arb: combinational same-address write arbiter.
//   wr_req   [PORTS]          write request per port
//   addr     [PORTS][ADDR_W]  write address per port
//   grant    [PORTS]          write may commit (lowest-numbered port wins per address)
//   conflict 1                two or more requesting ports share an address
module mem_wr_arb #(
  parameter int unsigned PORTS  = 4,
  parameter int unsigned ADDR_W = 13
) (
  input  logic [PORTS-1:0]             wr_req,
  input  logic [PORTS-1:0][ADDR_W-1:0] addr,
  output logic [PORTS-1:0]             grant,
  output logic                         conflict
);

  always_comb begin
    grant    = wr_req;
    conflict = 1'b0;
    // A port loses if any lower-numbered port writes the same word.
    for (int p = 1; p < PORTS; p++) begin
      for (int q = 0; q < p; q++) begin
        if (wr_req[p] && wr_req[q] && (addr[p] == addr[q])) begin
          grant[p] = 1'b0;
          conflict = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_mport.sv
// mem_mport: parametrised multi-port synchronous memory with post-reset zero sweep,
// registered read-valid handshake and lowest-port-wins write collision resolution.
// Optional feature macro: MEM_BYTE_EN (per-byte write enables on every port).
//   i_clk  clock, rising edge
//   i_rst  synchronous active-high reset, restarts the clear sweep
//   bus    mem_mport_if.slave: op/addr/wdata[/be] in, rdata/valid/busy/wr_conflict out
module mem_mport
  import mem_pkg::*;
#(
  parameter int unsigned PORTS  = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 13
) (
  input  logic        i_clk,
  input  logic        i_rst,
  mem_mport_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef MEM_BYTE_EN
  localparam int unsigned BYTES = DATA_W / 8;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  mem_state_t                   state_q, state_d;
  logic [ADDR_W-1:0]            ptr_q, ptr_d;
  logic [PORTS-1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic [PORTS-1:0]             valid_q, valid_d;
  logic                         busy_q;
  logic                         conflict_q, conflict_d;

  logic [PORTS-1:0] wr_req;
  logic [PORTS-1:0] grant;
  logic             arb_conflict;

  always_comb begin
    wr_req = '0;
    for (int p = 0; p < PORTS; p++) begin
      wr_req[p] = (state_q == RUN) && (mem_op_t'(bus.op[p]) == MEM_OP_WRITE);
    end
  end

  mem_wr_arb #(
    .PORTS  (PORTS),
    .ADDR_W (ADDR_W)
  ) u_wr_arb (
    .wr_req   (wr_req),
    .addr     (bus.addr),
    .grant    (grant),
    .conflict (arb_conflict)
  );

  // Next state and registered outputs. Reads see the array before this edge's writes,
  // which gives read-first behaviour for same-address read/write pairs.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rdata_d    = '0;
    valid_d    = '0;
    conflict_d = 1'b0;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        for (int p = 0; p < PORTS; p++) begin
          if (mem_op_t'(bus.op[p]) == MEM_OP_READ) begin
            rdata_d[p] = mem[bus.addr[p]];
            valid_d[p] = 1'b1;
          end
        end
        conflict_d = arb_conflict;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= CLEAR;
      ptr_q      <= '0;
      rdata_q    <= '0;
      valid_q    <= '0;
      busy_q     <= 1'b1;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      busy_q     <= (state_d == CLEAR);
      conflict_q <= conflict_d;
    end
  end

  // Storage has no reset; the CLEAR sweep zeroes it one word per edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state_q == CLEAR) begin
        mem[ptr_q] <= '0;
      end else begin
        for (int p = 0; p < PORTS; p++) begin
          if (grant[p]) begin
`ifdef MEM_BYTE_EN
            for (int k = 0; k < BYTES; k++) begin
              if (bus.be[p][k]) begin
                mem[bus.addr[p]][k*8 +: 8] <= bus.wdata[p][k*8 +: 8];
              end
            end
`else
            mem[bus.addr[p]] <= bus.wdata[p];
`endif
          end
        end
      end
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.valid       = valid_q;
  assign bus.busy        = busy_q;
  assign bus.wr_conflict = conflict_q;

endmodule

// File: doc/mem_mport.md
# mem_mport

Parametrised multi-port synchronous memory: the next generation of the team's fixed 4×64-bit, 8K-word scratch memory. It adds:
- configurable port count, data width and depth;
- a hardware clear sequence after reset;
- a registered read-valid handshake;
- deterministic resolution of same-address write collisions, plus a collision flag.

It sits between the execution units' load/store ports and storage, one port per unit.

## Interface
- PORTS, 4, number of independent access ports
- DATA_W, 64, word width in bits; must be a multiple of 8
- ADDR_W, 13, address width; DEPTH = 2**ADDR_W words
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_op  in  [PORTS][2]  per-port op: 0 NONE, 1 READ, 2 WRITE, 3 reserved (treated as NONE)
- i_addr  in  [PORTS][ADDR_W]  per-port word address
- i_data  in  [PORTS][DATA_W]  per-port write data
- i_be  in  [PORTS][DATA_W/8]  per-port byte enables (present only with MEM_BYTE_EN)
- o_data  out  [PORTS][DATA_W]  per-port read data, registered
- o_valid  out  [PORTS]  one-cycle pulse: o_data of that port holds a read result
- o_busy  out  1  high while reset or clear sequence in progress; requests ignored
- o_wr_conflict  out  1  pulse: two or more WRITE ports targeted one address in the previous cycle

## Operation
- State machine, two states:
  - CLEAR: entered on any edge with i_rst=1, which also sets clear pointer ptr=0.
    - Each edge in CLEAR with i_rst=0 writes mem[ptr]=0 and then increments ptr.
    - At ptr==DEPTH-1 the zero is written and the state becomes RUN.
  - RUN: all ports are serviced every cycle; no back-pressure.
- Reset values: o_data all 0, o_valid all 0, o_busy 1, o_wr_conflict 0, state CLEAR, ptr 0.
- In CLEAR, all i_op are ignored: no memory side effects, o_valid=0, o_data=0.
- READ: o_data[p] <= mem[i_addr[p]], o_valid[p] <= 1.
- NONE, reserved op or WRITE: o_data[p] <= 0, o_valid[p] <= 0.
- Read-first semantics: a read and a write to the same address on the same edge return the old word. The written value is visible to reads on the following edge.
- Write collision, two or more WRITE ports with equal address on one edge:
  - the lowest-numbered port wins; the other writes to that address are dropped;
  - o_wr_conflict <= 1 for one cycle.
- Writes to distinct addresses all commit on the same edge.
- Reset mid-operation: i_rst=1 in RUN or CLEAR restarts CLEAR from ptr 0. In-flight o_valid pulses are cleared. Memory contents are undefined until the sweep overwrites them.

## Timing
- Read latency 1 cycle: request sampled on edge N; o_data/o_valid valid after edge N until edge N+1.
- Write latency 1 cycle: committed on the sampling edge.
- Clear duration: exactly DEPTH edges after the first edge with i_rst=0.
- o_busy falls after the final clear edge; the first request is accepted on the next edge.
- o_busy is registered and equals (state==CLEAR).
- o_wr_conflict is asserted in the same cycle as the o_valid results of the colliding edge.
- No combinational path from any input to any output.

## Configuration
- MEM_BYTE_EN defined:
  - i_busy-independent port i_be exists; WRITE updates only bytes k where i_be[p][k]=1;
  - i_be all-zero makes WRITE a no-op that still participates in collision detection;
  - collision resolution is per word, not per byte: the winner's enabled bytes only.
- MEM_BYTE_EN undefined: no i_be port; every WRITE replaces the full word.

## Structure
- Package mem_pkg holds:
  - op type mem_op_t with constants MEM_OP_NONE, MEM_OP_READ, MEM_OP_WRITE;
  - state type mem_state_t (CLEAR, RUN).
- Sub-module mem_wr_arb:
  - combinational, PORTS-wide;
  - inputs: write requests and addresses;
  - outputs: per-port write-grant mask and conflict flag;
  - the top-level memory array and CLEAR FSM live in mem_mport.

## Test plan
Parameters for all scenarios: PORTS=4, DATA_W=64, ADDR_W=4.
- Clear: hold i_rst 3 cycles then release → o_busy high for exactly 16 cycles, then 0. Reading addr 0..15 on all ports returns 0 with o_valid=1 one cycle later.
- Basic R/W: port 2 writes 0xDEAD_BEEF to addr 5; next cycle port 0 reads addr 5 → o_data[0]=0xDEADBEEF and o_valid=0b0001 one cycle after the read.
- Read-first: port 0 writes 0x11 to addr 3 while port 1 reads addr 3 (old value 0) → o_data[1]=0. Re-read next cycle → 0x11.
- Collision: ports 1, 3 write 0xAA, 0xBB to addr 7 on the same edge → o_wr_conflict pulses once; a later read of addr 7 returns 0xAA.
- Byte enable (MEM_BYTE_EN): addr 2 = 0x0, write 0xFFFF_FFFF_FFFF_FFFF with i_be=0x0F → readback 0x0000_0000_FFFF_FFFF.
- Reset mid-run: write 0x55 to addr 9, assert i_rst 1 cycle during an active read → o_valid=0 next cycle, o_busy=1 for 16 cycles, addr 9 reads 0.
